// File: rtl/tt_sel_seq_pkg.sv
// Shared types for the tiny-tapeout design-select sequencer: FSM state
// encoding, phase-counter width and the phase reload helper.
package tt_sel_seq_pkg;

  localparam int PHASE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_INC_HI,
    ST_INC_LO,
    ST_SETTLE,
    ST_ACTIVE
  } state_t;

  // The phase counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
    return PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/tt_sel_seq_if.sv
// Valid/ready request channel carrying the target design-select address.
interface tt_sel_seq_if #(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready
  );

endinterface

// File: rtl/tt_sel_seq.sv
// Design-select sequencer: resets the external mux controller, then issues
// one increment pulse per address step before enabling the selected design.
module tt_sel_seq
  import tt_sel_seq_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int PULSE_CYC = 2,
  parameter int RST_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  tt_sel_seq_if.slave       req,
  input  logic              disable_req,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam logic [PHASE_W-1:0] RST_LOAD   = phase_load(RST_CYC);
  localparam logic [PHASE_W-1:0] PULSE_LOAD = phase_load(PULSE_CYC);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  lat_addr;
  logic [ADDR_W-1:0]  inc_cnt;
  logic [ADDR_W-1:0]  inc_cnt_nxt;
  logic               phase_done;
  logic               accept;

  assign accept      = req.req_valid && req.req_ready;
  assign phase_done  = (phase == '0);
  // inc_cnt never exceeds lat_addr, so the top address completes without wrap.
  assign inc_cnt_nxt = inc_cnt + ADDR_W'(1);

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      phase          <= '0;
      lat_addr       <= '0;
      inc_cnt        <= '0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      req.req_ready  <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      cur_addr       <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE, ST_ACTIVE: begin
          // A new request outranks disable when both arrive in ACTIVE.
          if (accept) begin
            lat_addr       <= req.req_addr;
            inc_cnt        <= '0;
            phase          <= RST_LOAD;
            ctrl_ena       <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            req.req_ready  <= 1'b0;
            busy           <= 1'b1;
            state          <= ST_RST;
          end else if (state == ST_ACTIVE && disable_req) begin
            ctrl_ena <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        ST_RST: begin
          if (phase_done) begin
            ctrl_sel_rst_n <= 1'b1;
            phase          <= PULSE_LOAD;
            if (lat_addr == '0) begin
              state <= ST_SETTLE;
            end else begin
              ctrl_sel_inc <= 1'b1;
              state        <= ST_INC_HI;
            end
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end

        ST_INC_HI: begin
          if (phase_done) begin
            ctrl_sel_inc <= 1'b0;
            phase        <= PULSE_LOAD;
            state        <= ST_INC_LO;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end

        ST_INC_LO: begin
          if (phase_done) begin
            inc_cnt <= inc_cnt_nxt;
            phase   <= PULSE_LOAD;
            if (inc_cnt_nxt == lat_addr) begin
              state <= ST_SETTLE;
            end else begin
              ctrl_sel_inc <= 1'b1;
              state        <= ST_INC_HI;
            end
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end

        ST_SETTLE: begin
          if (phase_done) begin
            ctrl_ena      <= 1'b1;
            done          <= 1'b1;
            cur_addr      <= lat_addr;
            req.req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_ACTIVE;
          end else begin
            phase <= phase - PHASE_W'(1);
          end
        end

        default: begin
          ctrl_sel_rst_n <= 1'b1;
          ctrl_sel_inc   <= 1'b0;
          ctrl_ena       <= 1'b0;
          req.req_ready  <= 1'b1;
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

  // The controller must never see an increment while it is held in reset.
  a_no_inc_in_rst: assert property (@(posedge clk) disable iff (rst)
    !(ctrl_sel_inc && !ctrl_sel_rst_n));

  a_done_with_ena: assert property (@(posedge clk) disable iff (rst)
    done |-> ctrl_ena);

  a_ready_not_busy: assert property (@(posedge clk) disable iff (rst)
    req.req_ready == !busy);

endmodule

// File: doc/tt_sel_seq.md
TT_SEL_SEQ -- requirements
Module: tt_sel_seq

Interface
REQ-001 Parameter ADDR_W, default 10: width of the design-select address.
REQ-002 Parameter PULSE_CYC, default 2: clk cycles per inc high phase, per inc low phase, and for settle (range 1..255).
REQ-003 Parameter RST_CYC, default 4: clk cycles that ctrl_sel_rst_n is held low (range 1..255).
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  select request is valid.
REQ-007 req_addr  in  ADDR_W  target design address; sampled only on accept.
REQ-008 req_ready  out  1  ready for a request; accept occurs when req_valid && req_ready.
REQ-009 disable  in  1  drop ctrl_ena while ACTIVE.
REQ-010 ctrl_sel_rst_n  out  1  selector reset to the controller, active-low.
REQ-011 ctrl_sel_inc  out  1  selector increment strobe to the controller.
REQ-012 ctrl_ena  out  1  enable for the selected design.
REQ-013 busy  out  1  high in any state except IDLE and ACTIVE.
REQ-014 done  out  1  one-cycle pulse on the cycle ctrl_ena first rises.
REQ-015 cur_addr  out  ADDR_W  last fully applied address.

Function
REQ-016 The FSM SHALL have states IDLE, RST, INC_HI, INC_LO, SETTLE and ACTIVE, and all outputs SHALL be registered.
REQ-017 req_ready SHALL be high only in IDLE and ACTIVE.
REQ-018 On accept, the block SHALL latch req_addr, clear ctrl_ena, and enter RST on the next cycle.
REQ-019 RST SHALL drive ctrl_sel_rst_n=0 for exactly RST_CYC cycles; ctrl_sel_rst_n SHALL be 1 in all other states.
REQ-020 After RST, if the latched address is 0 the block SHALL go to SETTLE; otherwise it SHALL go to INC_HI.
REQ-021 INC_HI SHALL drive ctrl_sel_inc=1 for PULSE_CYC cycles, then go to INC_LO.
REQ-022 INC_LO SHALL drive ctrl_sel_inc=0 for PULSE_CYC cycles and count one pulse; when the count reaches the latched address it SHALL go to SETTLE, otherwise back to INC_HI.
REQ-023 The block SHALL emit exactly addr inc pulses, with ctrl_sel_inc never high while ctrl_sel_rst_n=0.
REQ-024 SETTLE SHALL last PULSE_CYC cycles, then enter ACTIVE with ctrl_ena=1, done=1 for that one cycle, and cur_addr set to the latched address.
REQ-025 Latency SHALL be: with accept at cycle 0, ctrl_ena rises at cycle 1+RST_CYC+2*PULSE_CYC*addr+PULSE_CYC.
REQ-026 In ACTIVE, disable=1 SHALL clear ctrl_ena next cycle and return to IDLE; cur_addr SHALL be retained.
REQ-027 If disable and an accept occur in the same ACTIVE cycle, the accept SHALL win and a new sequence SHALL start.
REQ-028 req_valid during busy SHALL be ignored, with no queuing.
REQ-029 The inc counter SHALL be ADDR_W bits wide, and addr=2^ADDR_W-1 SHALL complete without wrap.
REQ-030 The phase counter SHALL be 8 bits wide and reload on every state entry.

Reset
REQ-031 While rst is high the block SHALL force state=IDLE, ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, req_ready=1, busy=0, done=0, cur_addr=0, and clear all counters.
REQ-032 An rst asserted mid-sequence SHALL abort on the next edge with no further inc pulse, and the block SHALL be ready the cycle after rst deasserts.

Structure
REQ-033 The FSM state enum and the phase-counter width SHALL live in the shared tt package.
REQ-034 The block SHALL be one flat module; a sub-module for the phase timer is optional as tt_sel_timer (load value, expire flag).

Verification
REQ-035 PULSE_CYC=2, RST_CYC=4, addr=3 -> rst_n low cycles 1-4; inc high 5-6, 9-10, 13-14; ctrl_ena and done at cycle 19; cur_addr=3.
REQ-036 addr=0 -> zero inc pulses; ctrl_ena at cycle 7.
REQ-037 In ACTIVE with addr 5 applied, request addr=2 -> ctrl_ena drops at cycle 1; 2 pulses; cur_addr=2 at cycle 15.
REQ-038 rst at cycle 8 during addr=3 -> outputs at reset values from cycle 9, no inc high after cycle 8; a new request accepted afterward completes normally.
REQ-039 req_valid held during busy with a different addr -> ignored; in ACTIVE, disable together with req_valid -> new sequence starts.
REQ-040 ADDR_W=4, addr=15 -> exactly 15 pulses; ctrl_ena at cycle 67.
